// File: rtl/conv_ctrl_pkg.sv
// Shared types and puncture tables for the convolutional encoder frame sequencer.
// Rate and state encodings, puncture keep masks and the default tail length.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'd0,
    RATE_2_3  = 2'd1,
    RATE_3_4  = 2'd2,
    RATE_RSVD = 2'd3
  } rate_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DATA,
    ST_TAIL,
    ST_DONE
  } state_e;

  localparam int unsigned TAIL_BITS_DEF = 6;

  localparam logic [1:0] KEEP_AB = 2'b11;
  localparam logic [1:0] KEEP_A  = 2'b10;
  localparam logic [1:0] KEEP_B  = 2'b01;

  // Final phase index of each puncture pattern; reserved runs as 1/2.
  function automatic logic [1:0] punct_last_phase(input rate_e rate);
    case (rate)
      RATE_2_3: return 2'd1;
      RATE_3_4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] punct_mask(input rate_e rate, input logic [1:0] phase);
    logic [1:0] mask;
    mask = KEEP_AB;
    case (rate)
      RATE_2_3: mask = (phase == 2'd1) ? KEEP_A : KEEP_AB;
      RATE_3_4: begin
        case (phase)
          2'd1:    mask = KEEP_A;
          2'd2:    mask = KEEP_B;
          default: mask = KEEP_AB;
        endcase
      end
      default:  mask = KEEP_AB;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/conv_punct_phase.sv
// Puncture phase counter and keep-mask lookup.
// Phase restarts on clr and steps once per accepted encoder beat.
import conv_ctrl_pkg::*;

module conv_punct_phase (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  input  rate_e      rate,
  output logic [1:0] keep
);

  logic [1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (adv) begin
      phase <= (phase >= punct_last_phase(rate)) ? 2'd0 : phase + 2'd1;
    end
  end

  always_comb begin
    keep = punct_mask(rate, phase);
  end

endmodule

// File: rtl/conv_enc_seq.sv
// Frame sequencer: serialises item bytes MSB-first into the K=7 encoder,
// clears it per frame, appends optional zero tail and drives puncture masks.
import conv_ctrl_pkg::*;

module conv_enc_seq #(
  parameter int unsigned ITEM_W    = 8,
  parameter int unsigned TAIL_BITS = TAIL_BITS_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              ce_clk,
  input  logic              ce_rst_n,
  input  logic [1:0]        cfg_rate,
  input  logic              cfg_term_en,
  input  logic [ITEM_W-1:0] s_tdata,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic              enc_clear,
  output logic              enc_bit,
  output logic [1:0]        enc_keep,
  output logic              enc_valid,
  output logic              enc_last,
  input  logic              enc_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned TW = $clog2(TAIL_BITS) + 1;

  state_e            state, state_nxt;
  logic [ITEM_W-1:0] byte_q;
  logic              last_q;
  logic              term_q;
  rate_e             rate_q;
  logic              held;
  logic [2:0]        bit_idx;
  logic [TW-1:0]     tail_cnt;
  logic              rdy_en;
  logic              beat;
  logic              load;
  logic              tail_end;
  logic [1:0]        keep;

  assign tail_end = (tail_cnt == TW'(TAIL_BITS - 1));

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // held=0 in DATA means the previous byte ran out and none was waiting;
  // the bit stream pauses there until the next byte is loaded.
  always_comb begin
    state_nxt  = state;
    s_tready   = 1'b0;
    enc_clear  = 1'b0;
    enc_valid  = 1'b0;
    enc_bit    = 1'b0;
    enc_last   = 1'b0;
    frame_done = 1'b0;
    beat       = 1'b0;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        s_tready = rdy_en;
        if (rdy_en && s_tvalid) begin
          load      = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        enc_clear = 1'b1;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (held) begin
          enc_valid = 1'b1;
          enc_bit   = byte_q[~bit_idx];
          enc_last  = last_q && !term_q && (bit_idx == 3'd7);
          beat      = enc_ready;
          if (enc_ready && (bit_idx == 3'd7)) begin
            if (last_q) begin
              state_nxt = term_q ? ST_TAIL : ST_DONE;
            end else begin
              s_tready = 1'b1;
              load     = s_tvalid;
            end
          end
        end else begin
          s_tready = 1'b1;
          load     = s_tvalid;
        end
      end
      ST_TAIL: begin
        enc_valid = 1'b1;
        enc_last  = tail_end;
        beat      = enc_ready;
        if (enc_ready && tail_end) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      byte_q    <= '0;
      last_q    <= 1'b0;
      term_q    <= 1'b0;
      rate_q    <= RATE_1_2;
      held      <= 1'b0;
      bit_idx   <= '0;
      tail_cnt  <= '0;
      rdy_en    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (load) begin
        byte_q <= s_tdata;
        last_q <= s_tlast;
      end
      if (state == ST_IDLE && load) begin
        rate_q <= rate_e'(cfg_rate);
        term_q <= cfg_term_en;
      end
      case (state)
        ST_CLEAR: begin
          bit_idx  <= '0;
          tail_cnt <= '0;
          held     <= 1'b1;
        end
        ST_DATA: begin
          if (beat) begin
            bit_idx <= bit_idx + 3'd1;
          end
          if (!held) begin
            held <= load;
          end else if (beat && (bit_idx == 3'd7)) begin
            held <= load;
          end
        end
        ST_TAIL: begin
          if (beat) begin
            tail_cnt <= tail_cnt + TW'(1);
          end
        end
        ST_DONE: begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  conv_punct_phase u_punct (
    .clk   (ce_clk),
    .rst_n (ce_rst_n),
    .clr   (state == ST_CLEAR),
    .adv   (beat),
    .rate  (rate_q),
    .keep  (keep)
  );

  assign enc_keep = enc_valid ? keep : 2'b00;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_conv_enc_seq.sv
// Directed bench for conv_enc_seq: frames of known bytes, expected bits,
// keep masks, tail, stalls, mid-frame config change and asynchronous reset.
module tb_conv_enc_seq;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n = 1'b0;
  logic [1:0]  cfg_rate = 2'd0;
  logic        cfg_term_en = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        enc_clear;
  logic        enc_bit;
  logic [1:0]  enc_keep;
  logic        enc_valid;
  logic        enc_last;
  logic        enc_ready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  always #5 ce_clk = ~ce_clk;

  conv_enc_seq #(.ITEM_W(8), .TAIL_BITS(6), .CNT_W(16)) dut (
    .ce_clk      (ce_clk),
    .ce_rst_n    (ce_rst_n),
    .cfg_rate    (cfg_rate),
    .cfg_term_en (cfg_term_en),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .enc_clear   (enc_clear),
    .enc_bit     (enc_bit),
    .enc_keep    (enc_keep),
    .enc_valid   (enc_valid),
    .enc_last    (enc_last),
    .enc_ready   (enc_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Beat monitor: everything observed is appended; the main flow works on deltas.
  logic       bits_q[$];
  logic [1:0] keeps_q[$];
  int         last_at = -1;
  int         n_clear = 0;
  int         n_done = 0;
  int         n_kept = 0;
  int         stall_viol = 0;
  logic       pv_stall = 1'b0;
  logic       pv_bit = 1'b0;
  logic       pv_last = 1'b0;
  logic [1:0] pv_keep = 2'b00;
  bit         rand_stall = 1'b0;

  always @(negedge ce_clk) begin
    if (enc_clear) n_clear <= n_clear + 1;
    if (frame_done) n_done <= n_done + 1;
    if (ce_rst_n && pv_stall &&
        !(enc_valid && enc_bit == pv_bit && enc_keep == pv_keep && enc_last == pv_last))
      stall_viol <= stall_viol + 1;
    pv_stall <= ce_rst_n && enc_valid && !enc_ready;
    pv_bit   <= enc_bit;
    pv_keep  <= enc_keep;
    pv_last  <= enc_last;
    if (enc_valid && enc_ready) begin
      if (enc_last) last_at <= bits_q.size();
      n_kept <= n_kept + int'(enc_keep[1]) + int'(enc_keep[0]);
      bits_q.push_back(enc_bit);
      keeps_q.push_back(enc_keep);
    end
  end

  initial forever begin
    @(posedge ce_clk);
    #1;
    enc_ready = rand_stall ? ($urandom_range(3) != 0) : 1'b1;
  end

  int base_b, base_clear, base_done, base_kept, base_viol;
  logic [7:0] src_q[$];

  task automatic mark();
    base_b     = bits_q.size();
    base_clear = n_clear;
    base_done  = n_done;
    base_kept  = n_kept;
    base_viol  = stall_viol;
  endtask

  task automatic drive_src(input bit stall);
    int idx = 0;
    int guard = 0;
    logic hs;
    @(posedge ce_clk);
    #1;
    while (idx < src_q.size() && guard < 2000) begin
      if (!s_tvalid) s_tvalid = stall ? ($urandom_range(3) != 0) : 1'b1;
      s_tdata = src_q[idx];
      s_tlast = (idx == src_q.size() - 1);
      @(negedge ce_clk);
      hs = s_tvalid && s_tready;
      @(posedge ce_clk);
      #1;
      if (hs) begin
        idx++;
        s_tvalid = 1'b0;
      end
      guard++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check_eq("src_drain", 64'(idx), 64'(src_q.size()));
  endtask

  task automatic wait_done();
    int g = 0;
    while (!frame_done && g < 3000) begin
      @(negedge ce_clk);
      g++;
    end
    check_eq("done_seen", 64'(frame_done), 64'd1);
    @(posedge ce_clk);
    #1;
  endtask

  task automatic run_frame(input logic [1:0] rate, input logic term, input bit stall);
    cfg_rate    = rate;
    cfg_term_en = term;
    rand_stall  = stall;
    mark();
    drive_src(stall);
    wait_done();
    rand_stall = 1'b0;
  endtask

  function automatic logic [63:0] beats_vec(input int from, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], bits_q[from + i]};
    return v;
  endfunction

  function automatic logic [63:0] keep_vec(input int from, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[61:0], keeps_q[from + i]};
    return v;
  endfunction

  function automatic logic [63:0] src_vec(input int tail);
    logic [63:0] v = '0;
    for (int i = 0; i < src_q.size(); i++) v = {v[55:0], src_q[i]};
    for (int i = 0; i < tail; i++) v = {v[62:0], 1'b0};
    return v;
  endfunction

  function automatic logic [1:0] model_keep(input logic [1:0] rate, input int j);
    if (rate == 2'd1) return (j % 2 == 0) ? 2'b11 : 2'b10;
    if (rate == 2'd2) begin
      if (j % 3 == 0) return 2'b11;
      if (j % 3 == 1) return 2'b10;
      return 2'b01;
    end
    return 2'b11;
  endfunction

  function automatic int keep_err(input int from, input int n, input logic [1:0] rate);
    int e = 0;
    for (int j = 0; j < n; j++) if (keeps_q[from + j] !== model_keep(rate, j)) e++;
    return e;
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({s_tready, enc_clear, enc_bit, enc_keep, enc_valid, enc_last, busy, frame_done});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, g;
    repeat (3) @(posedge ce_clk);
    @(negedge ce_clk);
    check_eq("rst_outputs", out_vec(), 64'd0);
    check_eq("rst_cnt", 64'(frame_cnt), 64'd0);
    @(posedge ce_clk);
    #1 ce_rst_n = 1'b1;

    // 1: five bytes, rate 1/2, no tail
    src_q = '{8'd57, 8'd95, 8'd22, 8'd163, 8'd46};
    run_frame(2'd0, 1'b0, 1'b0);
    nb = bits_q.size() - base_b;
    check_eq("t1_clear", 64'(n_clear - base_clear), 64'd1);
    check_eq("t1_beats", 64'(nb), 64'd40);
    check_eq("t1_first8", beats_vec(base_b, 8), 64'b00111001);
    check_eq("t1_bits", beats_vec(base_b, 40), src_vec(0));
    check_eq("t1_keep", 64'(keep_err(base_b, 40, 2'd0)), 64'd0);
    check_eq("t1_last_at", 64'(last_at), 64'(base_b + 39));
    check_eq("t1_done", 64'(n_done - base_done), 64'd1);
    check_eq("t1_cnt", 64'(frame_cnt), 64'd1);
    check_eq("t1_idle", out_vec(), 64'h100);

    // 2: same bytes, rate 2/3, with tail
    run_frame(2'd1, 1'b1, 1'b0);
    nb = bits_q.size() - base_b;
    check_eq("t2_beats", 64'(nb), 64'd46);
    check_eq("t2_bits", beats_vec(base_b, 46), src_vec(6));
    check_eq("t2_tail", beats_vec(base_b + 40, 6), 64'd0);
    check_eq("t2_keep", 64'(keep_err(base_b, 46, 2'd1)), 64'd0);
    check_eq("t2_kept", 64'(n_kept - base_kept), 64'd69);
    check_eq("t2_last_at", 64'(last_at), 64'(base_b + 45));
    check_eq("t2_cnt", 64'(frame_cnt), 64'd2);

    // 3: single byte, rate 3/4
    src_q = '{8'hA5};
    run_frame(2'd2, 1'b0, 1'b0);
    check_eq("t3_beats", 64'(bits_q.size() - base_b), 64'd8);
    check_eq("t3_bits", beats_vec(base_b, 8), 64'b10100101);
    check_eq("t3_keep", keep_vec(base_b, 8), 64'b1110011110011110);
    check_eq("t3_last_at", 64'(last_at), 64'(base_b + 7));
    check_eq("t3_cnt", 64'(frame_cnt), 64'd3);

    // 4: test 1 with random stalls on both sides
    src_q = '{8'd57, 8'd95, 8'd22, 8'd163, 8'd46};
    run_frame(2'd0, 1'b0, 1'b1);
    check_eq("t4_beats", 64'(bits_q.size() - base_b), 64'd40);
    check_eq("t4_bits", beats_vec(base_b, 40), src_vec(0));
    check_eq("t4_keep", 64'(keep_err(base_b, 40, 2'd0)), 64'd0);
    check_eq("t4_stable", 64'(stall_viol - base_viol), 64'd0);
    check_eq("t4_last_at", 64'(last_at), 64'(base_b + 39));
    check_eq("t4_cnt", 64'(frame_cnt), 64'd4);

    // 5: rate change mid-frame is ignored until the next frame
    src_q = '{8'h12, 8'h34};
    cfg_rate = 2'd0;
    cfg_term_en = 1'b0;
    mark();
    fork
      drive_src(1'b0);
      begin
        g = 0;
        while (!busy && g < 100) begin
          @(negedge ce_clk);
          g++;
        end
        repeat (3) @(negedge ce_clk);
        cfg_rate = 2'd2;
      end
    join
    wait_done();
    check_eq("t5a_beats", 64'(bits_q.size() - base_b), 64'd16);
    check_eq("t5a_keep", 64'(keep_err(base_b, 16, 2'd0)), 64'd0);
    src_q = '{8'hF0};
    run_frame(2'd2, 1'b0, 1'b0);
    check_eq("t5b_keep", keep_vec(base_b, 8), 64'b1110011110011110);
    check_eq("t5b_bits", beats_vec(base_b, 8), 64'hF0);
    src_q = '{8'h0F};
    run_frame(2'd3, 1'b1, 1'b0);
    check_eq("t5c_beats", 64'(bits_q.size() - base_b), 64'd14);
    check_eq("t5c_keep", 64'(keep_err(base_b, 14, 2'd0)), 64'd0);
    check_eq("t5_cnt", 64'(frame_cnt), 64'd7);

    // 6: asynchronous reset while beat 13 is presented
    cfg_rate = 2'd0;
    cfg_term_en = 1'b0;
    mark();
    @(posedge ce_clk);
    #1;
    s_tdata  = 8'hFF;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    g = 0;
    while ((bits_q.size() - base_b) < 12 && g < 500) begin
      @(negedge ce_clk);
      #2;
      g++;
    end
    check_eq("t6_reach13", 64'(bits_q.size() - base_b), 64'd12);
    check_eq("t6_pre_valid", 64'(enc_valid), 64'd1);
    ce_rst_n = 1'b0;
    #1;
    check_eq("t6_rst_outputs", out_vec(), 64'd0);
    check_eq("t6_rst_cnt", 64'(frame_cnt), 64'd0);
    s_tvalid = 1'b0;
    repeat (2) @(posedge ce_clk);
    #1 ce_rst_n = 1'b1;
    src_q = '{8'h80};
    run_frame(2'd0, 1'b0, 1'b0);
    check_eq("t6_clear", 64'(n_clear - base_clear), 64'd1);
    check_eq("t6_first_bit", 64'(bits_q[base_b]), 64'd1);
    check_eq("t6_bits", beats_vec(base_b, 8), 64'h80);
    check_eq("t6_beats", 64'(bits_q.size() - base_b), 64'd8);
    check_eq("t6_cnt", 64'(frame_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
